text_buffer_arbiter: RTL and testbench

- Owns the single-port character/attribute RAM that feeds the console renderer.
- Schedules one video prefetch read per 8-pixel cell, locked to cx/cy, and arbitrates host write requesters into the remaining RAM cycles.
- Sits in the clk_pixel domain between the pixel-position counters, the text RAM and console, replacing the free-running character counter.

---
 rtl/text_buffer_arbiter_if.sv | 25 ++
 rtl/text_buffer_arbiter.sv | 152 +++++++++++++++
 tb/tb_text_buffer_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_arbiter_if.sv
// Host write-requester handshake bundle for text_buffer_arbiter.
// Requester i owns bit i of req_valid/req_ready and slice i of req_addr/req_data.
interface text_buffer_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*16-1:0]         req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/text_buffer_arbiter.sv
// Text RAM owner: one video prefetch per 8-pixel cell, host writes in the free cycles.
// TEXT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module text_buffer_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525
) (
  input  logic                  clk_pixel,
  input  logic                  RESETn,
  input  logic [9:0]            cx,
  input  logic [9:0]            cy,
  text_buffer_arbiter_if.slave  req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  output logic [7:0]            character,
  output logic [7:0]            attribute,
  output logic                  drop_flag
);

  localparam int unsigned           PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH:0]   CELLS_L = (ADDR_WIDTH+1)'(COLS * ROWS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A  = ADDR_WIDTH'(COLS);
  localparam logic [9:0]            WRAP_X  = 10'(H_TOTAL - 8);
  localparam logic [9:0]            LAST_Y  = 10'(V_TOTAL - 1);
  localparam logic [9:0]            COLS_L  = 10'(COLS);
  localparam logic [9:0]            ROWS_L  = 10'(ROWS);
  localparam logic [15:0]           BLANK   = 16'h0F20;

  logic                  slot;
  logic                  video_rd;
  logic [9:0]            tgt_col;
  logic [9:0]            tgt_row;
  logic [ADDR_WIDTH-1:0] video_addr;

  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           sel_data;
  logic                  sel_in_range;

  logic                  vid_cell;
  logic [15:0]           fetch;

  // The slot at the start of a cell prefetches the following cell; the last
  // cell of a line targets column 0 of the next line (next frame at the bottom).
  always_comb begin
    slot = (cx[2:0] == 3'd0);
    if (cx == WRAP_X) begin
      tgt_col = '0;
      tgt_row = (cy == LAST_Y) ? '0 : ((cy + 10'd1) >> 4);
    end else begin
      tgt_col = (cx >> 3) + 10'd1;
      tgt_row = cy >> 4;
    end
    video_rd   = slot && (tgt_col < COLS_L) && (tgt_row < ROWS_L);
    video_addr = ADDR_WIDTH'(tgt_row) * COLS_A + ADDR_WIDTH'(tgt_col);
  end

`ifdef TEXT_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req.req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    grant_any = grant_any && !video_rd;
  end
`else
  logic [PTR_W-1:0] ptr;

  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_any && req.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    grant_any = grant_any && !video_rd;
  end

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    grant         = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    req.req_ready = grant;
    sel_addr      = req.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data      = req.req_data[grant_idx*16 +: 16];
    sel_in_range  = ({1'b0, sel_addr} < CELLS_L);
  end

  always_ff @(posedge clk_pixel or negedge RESETn) begin
    if (!RESETn) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      drop_flag <= 1'b0;
      vid_cell  <= 1'b0;
      fetch     <= BLANK;
      character <= 8'h20;
      attribute <= 8'h0F;
    end else begin
      if (video_rd) begin
        ram_addr <= video_addr;
        ram_we   <= 1'b0;
      end else if (grant_any) begin
        if (sel_in_range) begin
          ram_addr  <= sel_addr;
          ram_wdata <= sel_data;
          ram_we    <= 1'b1;
        end else begin
          ram_we    <= 1'b0;
          drop_flag <= 1'b1;
        end
      end else begin
        ram_we <= 1'b0;
      end

      // Read data for the cx==0 address is on ram_rdata during cx==2.
      if (slot) begin
        vid_cell <= video_rd;
      end
      if (cx[2:0] == 3'd2) begin
        fetch <= vid_cell ? ram_rdata : BLANK;
      end
      if (cx[2:0] == 3'd7) begin
        attribute <= fetch[15:8];
        character <= fetch[7:0];
      end
    end
  end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter with a cycle model feeding a scoreboard queue.
module tb_text_buffer_arbiter;

  localparam int NUM_REQ = 2;
  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int AW      = 12;
  localparam int HT      = 800;
  localparam int VT      = 525;
`ifdef TEXT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [15:0]   wdata;
    logic [7:0]    ch;
    logic [7:0]    at;
    logic          drop;
  } exp_t;

  logic          clk_pixel = 1'b0;
  logic          RESETn;
  logic [9:0]    cx, cy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic [7:0]    character, attribute;
  logic          drop_flag;

  text_buffer_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW)) rif ();

  text_buffer_arbiter #(
    .NUM_REQ(NUM_REQ), .COLS(COLS), .ROWS(ROWS),
    .ADDR_WIDTH(AW), .H_TOTAL(HT), .V_TOTAL(VT)
  ) dut (
    .clk_pixel (clk_pixel),
    .RESETn    (RESETn),
    .cx        (cx),
    .cy        (cy),
    .req       (rif),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .character (character),
    .attribute (attribute),
    .drop_flag (drop_flag)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [15:0] mem    [0:4095];
  logic [15:0] shadow [0:4095];

  always @(posedge clk_pixel) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  int            px, py;
  logic          rq_valid [NUM_REQ];
  logic [AW-1:0] rq_addr  [NUM_REQ];
  logic [15:0]   rq_data  [NUM_REQ];
  int            rq_cnt   [NUM_REQ];
  bit            rq_auto;

  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic          m_we, m_drop, m_vidcell;
  logic [15:0]   m_wdata, m_rdreg, m_fetch;
  logic [7:0]    m_char, m_attr;
  int            last_grant;
  logic [NUM_REQ-1:0] obs_ready;
  exp_t          sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      rif.req_valid[i]          = rq_valid[i];
      rif.req_addr[i*AW +: AW]  = rq_addr[i];
      rif.req_data[i*16 +: 16]  = rq_data[i];
    end
  endtask

  task automatic load_item(input int i);
    rq_addr[i] = AW'((i == 0 ? 100 : 300) + rq_cnt[i]);
    rq_data[i] = {8'(8'h10 * (i + 1) + rq_cnt[i]), 8'(8'h30 + rq_cnt[i])};
  endtask

  task automatic set_pos(input int x, input int y);
    px = x; py = y;
    cx = 10'(px); cy = 10'(py);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_drop = 1'b0;
    m_vidcell = 1'b0; m_fetch = 16'h0F20; m_char = 8'h20; m_attr = 8'h0F;
    sb.delete();
  endtask

  task automatic model_cycle();
    int col, row, g, idx, a;
    bit vid;
    logic [15:0] rd;
    logic [31:0] e_ready;
    exp_t e;
    if (px == HT - 8) begin
      col = 0;
      row = (py == VT - 1) ? 0 : (py + 1) / 16;
    end else begin
      col = px / 8 + 1;
      row = py / 16;
    end
    vid = (px % 8 == 0) && (col < COLS) && (row < ROWS);
    g = -1;
    if (!vid) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = FIXED ? k : (m_ptr + k) % NUM_REQ;
        if (g < 0 && rq_valid[idx]) g = idx;
      end
    end
    e_ready = (g < 0) ? 32'd0 : (32'd1 << g);
    obs_ready = rif.req_ready;
    check("req_ready", 32'(rif.req_ready), e_ready);

    rd = shadow[m_addr];
    if (m_we) shadow[m_addr] = m_wdata;
    if (px % 8 == 2) m_fetch = m_vidcell ? m_rdreg : 16'h0F20;
    m_rdreg = rd;
    if (px % 8 == 7) begin
      m_char = m_fetch[7:0];
      m_attr = m_fetch[15:8];
    end
    if (px % 8 == 0) m_vidcell = vid;
    if (vid) begin
      m_addr = AW'(row * COLS + col);
      m_we   = 1'b0;
    end else if (g >= 0) begin
      a = int'(rq_addr[g]);
      if (a < COLS * ROWS) begin
        m_addr = rq_addr[g]; m_wdata = rq_data[g]; m_we = 1'b1;
      end else begin
        m_we = 1'b0; m_drop = 1'b1;
      end
      m_ptr = (g + 1) % NUM_REQ;
    end else begin
      m_we = 1'b0;
    end
    last_grant = g;
    e.addr = m_addr; e.we = m_we; e.wdata = m_wdata;
    e.ch = m_char; e.at = m_attr; e.drop = m_drop;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    #1;
    model_cycle();
    @(posedge clk_pixel);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check("ram_addr",  32'(ram_addr),  32'(e.addr));
      check("ram_we",    32'(ram_we),    32'(e.we));
      check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
      check("character", 32'(character), 32'(e.ch));
      check("attribute", 32'(attribute), 32'(e.at));
      check("drop_flag", 32'(drop_flag), 32'(e.drop));
    end
    if (last_grant >= 0) begin
      if (rq_auto) begin
        rq_cnt[last_grant]++;
        load_item(last_grant);
      end else begin
        rq_valid[last_grant] = 1'b0;
      end
      drive_req();
    end
    px = px + 1;
    if (px == HT) begin
      px = 0;
      py = (py == VT - 1) ? 0 : py + 1;
    end
    cx = 10'(px); cy = 10'(py);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ram_addr"},  32'(ram_addr),  32'h0);
    check({tag, " ram_we"},    32'(ram_we),    32'h0);
    check({tag, " ram_wdata"}, 32'(ram_wdata), 32'h0);
    check({tag, " character"}, 32'(character), 32'h20);
    check({tag, " attribute"}, 32'(attribute), 32'h0F);
    check({tag, " drop_flag"}, 32'(drop_flag), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RESETn = 1'b0;
    set_pos(0, 0);
    rq_auto = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_valid[i] = 1'b0; rq_cnt[i] = 0; load_item(i);
    end
    drive_req();
    for (int a = 0; a < 4096; a++) begin
      mem[a]    = {8'(a * 7), 8'(a)};
      shadow[a] = {8'(a * 7), 8'(a)};
    end
    mem[1] = 16'h1F41; shadow[1] = 16'h1F41;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    #1;
    check_reset_values("reset");

    // Reset release at the top-left pixel: first fetch is cell 1.
    RESETn = 1'b1;
    step();
    check("first addr", 32'(ram_addr), 32'd1);
    repeat (7) step();
    check("cell1 char", 32'(character), 32'h41);
    check("cell1 attr", 32'(attribute), 32'h1F);
    repeat (7) begin
      step();
      check("cell1 hold", 32'({attribute, character}), 32'h1F41);
    end
    step();

    // Line wrap into text row 1, then frame wrap back to row 0.
    set_pos(784, 15);
    repeat (8) step();
    step();
    check("line wrap addr", 32'(ram_addr), 32'(COLS));
    repeat (15) step();
    set_pos(792, VT - 1);
    step();
    check("frame wrap addr", 32'(ram_addr), 32'd0);
    repeat (7) step();

    // Both requesters streaming through visible cells.
    set_pos(0, 32);
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1; drive_req();
    repeat (24) step();

    // Out-of-range write is accepted and dropped.
    rq_valid[0] = 1'b0; rq_valid[1] = 1'b0; drive_req();
    step();
    set_pos(1, 40);
    rq_auto = 1'b0;
    rq_valid[0] = 1'b1; rq_addr[0] = AW'(COLS * ROWS); drive_req();
    step();
    check("oor we", 32'(ram_we), 32'h0);
    check("oor drop", 32'(drop_flag), 32'h1);
    repeat (6) step();
    rq_auto = 1'b1; load_item(0);

    // Vertical blanking: every cycle is free, display shows blanks.
    set_pos(0, 480);
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1; drive_req();
    repeat (8) step();
    check("blank char", 32'(character), 32'h20);
    n = 0;
    repeat (8) begin
      step();
      if (obs_ready != '0) n++;
    end
    check("blank grants", 32'(n), 32'd8);

    // Reset in the middle of a fetch and a write stream.
    set_pos(0, 0);
    repeat (3) step();
    #2;
    RESETn = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge clk_pixel);
    #1;
    RESETn = 1'b1;
    set_pos(0, 0);
    repeat (16) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
